// File: rtl/rtx_pixel_packer_if.sv
// rtx_pixel_packer_if: pixel input, FIFO output handshake and status bundle for rtx_pixel_packer
interface rtx_pixel_packer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic          in_valid;
  logic [23:0]   in_color;
  logic [10:0]   in_h;
  logic [9:0]    in_v;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_pixel;
  logic [10:0]   out_h;
  logic [9:0]    out_v;
  logic          out_sof;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_count;
  logic [15:0]   oob_count;
  logic          overflow;
  modport slave (
    input  in_valid, in_color, in_h, in_v, out_ready,
    output out_valid, out_pixel, out_h, out_v, out_sof,
    output fifo_count, drop_count, oob_count, overflow
  );
  modport master (
    output in_valid, in_color, in_h, in_v, out_ready,
    input  out_valid, out_pixel, out_h, out_v, out_sof,
    input  fifo_count, drop_count, oob_count, overflow
  );
endinterface

// File: rtl/rtx_pixel_packer.sv
// rtx_pixel_packer: 8:8:8 -> RGB565 packer with range reject and FWFT FIFO (clk, rst_n, bus: rtx_pixel_packer_if.slave; optional RTX_PACKER_DITHER_EN)
module rtx_pixel_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int H_MAX      = 1280,
  parameter int V_MAX      = 720
) (
  input logic               clk,
  input logic               rst_n,
  rtx_pixel_packer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [11:0] H_LIM = 12'(H_MAX);
  localparam logic [10:0] V_LIM = 11'(V_MAX);
  logic [7:0] r_d, g_d, b_d;
  logic       in_oob, in_sof;
`ifdef RTX_PACKER_DITHER_EN
  logic [1:0] idx, bayer;
  logic [8:0] r_s, g_s, b_s;
  always_comb begin
    idx   = {bus.in_v[0], bus.in_h[0]};
    bayer = idx == 2'd0 ? 2'd0 : idx == 2'd1 ? 2'd2 : idx == 2'd2 ? 2'd3 : 2'd1;
    r_s   = {1'b0, bus.in_color[23:16]} + {6'b0, bayer, 1'b0};
    g_s   = {1'b0, bus.in_color[15:8]} + {7'b0, bayer};
    b_s   = {1'b0, bus.in_color[7:0]} + {6'b0, bayer, 1'b0};
    r_d   = r_s[8] ? 8'hFF : r_s[7:0];
    g_d   = g_s[8] ? 8'hFF : g_s[7:0];
    b_d   = b_s[8] ? 8'hFF : b_s[7:0];
  end
`else
  always_comb begin
    r_d = bus.in_color[23:16];
    g_d = bus.in_color[15:8];
    b_d = bus.in_color[7:0];
  end
`endif
  assign in_oob = ({1'b0, bus.in_h} >= H_LIM) || ({1'b0, bus.in_v} >= V_LIM);
  assign in_sof = (bus.in_h == '0) && (bus.in_v == '0);
  logic        s1_valid_q, s1_oob_q, s1_sof_q;
  logic [15:0] s1_pix_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_oob_q   <= 1'b0;
      s1_sof_q   <= 1'b0;
      s1_pix_q   <= '0;
      s1_h_q     <= '0;
      s1_v_q     <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_oob_q <= in_oob;
        s1_sof_q <= in_sof;
        s1_pix_q <= {r_d[7:3], g_d[7:2], b_d[7:3]};
        s1_h_q   <= bus.in_h;
        s1_v_q   <= bus.in_v;
      end
    end
  end
  logic [37:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [15:0]   drop_q, oob_q;
  logic          overflow_q;
  logic          empty, full, pop, accept, push, drop, oob_hit;
  logic [37:0]   head;
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && bus.out_ready;
  assign accept  = s1_valid_q && !s1_oob_q;
  // a full FIFO still takes the pixel when the head leaves in the same cycle
  assign push    = accept && (!full || pop);
  assign drop    = accept && !push;
  assign oob_hit = s1_valid_q && s1_oob_q;
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {s1_pix_q, s1_h_q, s1_v_q, s1_sof_q};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
      oob_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_q       <= wr_q + PW'(push);
      rd_q       <= rd_q + PW'(pop);
      drop_q     <= drop_q + 16'(drop && drop_q != 16'hFFFF);
      oob_q      <= oob_q + 16'(oob_hit && oob_q != 16'hFFFF);
      overflow_q <= overflow_q | drop;
    end
  end
  // unwritten memory is masked so an empty FIFO presents all-zero head fields
  assign head           = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign bus.out_valid  = !empty;
  assign bus.out_pixel  = head[37:22];
  assign bus.out_h      = head[21:11];
  assign bus.out_v      = head[10:1];
  assign bus.out_sof    = head[0];
  assign bus.fifo_count = wr_q - rd_q;
  assign bus.drop_count = drop_q;
  assign bus.oob_count  = oob_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_rtx_pixel_packer.sv
// tb_rtx_pixel_packer: directed self-checking bench for rtx_pixel_packer
module tb_rtx_pixel_packer;
  logic clk, rst_n;
  int checks = 0;
  int errors = 0;
  rtx_pixel_packer_if #(.FIFO_DEPTH(16)) bus ();
  rtx_pixel_packer #(.FIFO_DEPTH(16), .H_MAX(1280), .V_MAX(720)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
`ifdef RTX_PACKER_DITHER_EN
  localparam logic [15:0] DITH_EXP = 16'h0821;
`else
  localparam logic [15:0] DITH_EXP = 16'h0000;
`endif
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [23:0] c, input logic [10:0] h, input logic [9:0] v);
    bus.in_valid = 1'b1;
    bus.in_color = c;
    bus.in_h     = h;
    bus.in_v     = v;
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_color = '0;
    bus.in_h = '0;
    bus.in_v = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk_idle("rst");
    chk("rst_drop", 32'(bus.drop_count), 32'd0);
    chk("rst_oob", 32'(bus.oob_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_pix", 32'({bus.out_pixel, bus.out_sof}), 32'd0);
    chk("rst_hv", 32'({bus.out_h, bus.out_v}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    // single pixel, latency N+2
    bus.out_ready = 1'b1;
    send(24'hFF8040, 11'd5, 10'd3);
    chk("lat_n1", 32'(bus.out_valid), 32'd0);
    step();
    chk("one_valid", 32'(bus.out_valid), 32'd1);
    chk("one_pix", 32'(bus.out_pixel), 32'hFC08);
    chk("one_h", 32'(bus.out_h), 32'd5);
    chk("one_v", 32'(bus.out_v), 32'd3);
    chk("one_sof", 32'(bus.out_sof), 32'd0);
    step();
    chk_idle("one_pop");
    // out of range, plus the last in-range corner
    bus.out_ready = 1'b0;
    send(24'h123456, 11'd1280, 10'd0);
    send(24'h123456, 11'd0, 10'd720);
    send(24'h000000, 11'd1279, 10'd719);
    step();
    chk("oob_count", 32'(bus.oob_count), 32'd2);
    chk("oob_drop", 32'(bus.drop_count), 32'd0);
    chk("oob_fifo", 32'(bus.fifo_count), 32'd1);
    chk("edge_hv", 32'({bus.out_h, bus.out_v}), 32'({11'd1279, 10'd719}));
    bus.out_ready = 1'b1;
    step();
    chk_idle("oob_pop");
    // fill and overflow
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_color = {5'(i), 19'h0};
      bus.in_h = 11'(i);
      bus.in_v = 10'd0;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("fill_count", 32'(bus.fifo_count), 32'd16);
    chk("fill_drop", 32'(bus.drop_count), 32'd4);
    chk("fill_ovf", 32'(bus.overflow), 32'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_h", 32'(bus.out_h), 32'(i));
      chk("drain_pix", 32'(bus.out_pixel), 32'({5'(i), 11'h0}));
      chk("drain_sof", 32'(bus.out_sof), 32'(i == 0));
      step();
    end
    chk_idle("drain_end");
    // simultaneous push and pop while full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_h = 11'(100 + i);
      bus.in_v = 10'd1;
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk("full_count", 32'(bus.fifo_count), 32'd16);
    bus.in_valid = 1'b1;
    bus.in_h = 11'd200;
    step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_h = 11'(201 + k);
      chk("pp_count", 32'(bus.fifo_count), 32'd16);
      chk("pp_head", 32'(bus.out_h), 32'(100 + k));
      step();
    end
    bus.in_valid = 1'b0;
    chk("pp_drop", 32'(bus.drop_count), 32'd4);
    for (int j = 0; j < 17; j++) begin
      chk("pp_valid", 32'(bus.out_valid), 32'd1);
      chk("pp_order", 32'(bus.out_h), j < 6 ? 32'(110 + j) : 32'(194 + j));
      step();
    end
    chk_idle("pp_end");
    chk("pp_drop_end", 32'(bus.drop_count), 32'd4);
    // dither behaviour and saturation
    bus.out_ready = 1'b0;
    send(24'h070307, 11'd0, 10'd1);
    send(24'hFFFFFF, 11'd0, 10'd1);
    step();
    chk("dith_pix", 32'(bus.out_pixel), 32'(DITH_EXP));
    bus.out_ready = 1'b1;
    step();
    chk("dith_sat", 32'(bus.out_pixel), 32'hFFFF);
    step();
    chk_idle("dith_end");
    // asynchronous reset mid-stream, with a pixel held in stage 1
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_h = 11'(i + 1);
      bus.in_v = 10'd2;
      step();
    end
    bus.in_valid = 1'b0;
    chk("mid_count", 32'(bus.fifo_count), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_drop", 32'(bus.drop_count), 32'd0);
    chk("mid_oob", 32'(bus.oob_count), 32'd0);
    chk("mid_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("mid_s1_lost");
    send(24'h000000, 11'd7, 10'd9);
    chk("mid_lat_n1", 32'(bus.out_valid), 32'd0);
    step();
    chk("mid_lat_n2", 32'(bus.out_valid), 32'd1);
    chk("mid_hv", 32'({bus.out_h, bus.out_v}), 32'({11'd7, 10'd9}));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
